// File: rtl/cpu_datapath_pkg.sv
// Shared definitions for the CPU datapath: ALU operation codes, address widths
// and flag bit positions (flags exist only when DP_FLAGS_EN is defined).
package DatapathDefs;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4,
    ALU_XOR  = 3'd5,
    ALU_NOT  = 3'd6,
    ALU_INC  = 3'd7
  } alu_op;

  localparam int RF_ADDR_W = 4;
  localparam int DM_ADDR_W = 8;

  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

endpackage

// File: rtl/cpu_datapath_regfile.sv
// Register file: one synchronous write port, two combinational read ports,
// every entry cleared by the asynchronous reset.
module dp_regfile
  import DatapathDefs::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic                 Clk,
  input  logic                 ResetN,
  input  logic                 w_en,
  input  logic [RF_ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0]    w_data,
  input  logic [RF_ADDR_W-1:0] ra_addr,
  input  logic [RF_ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0]    ra_data,
  output logic [DATA_W-1:0]    rb_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (w_en) begin
      mem[w_addr] <= w_data;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write is visible next cycle.
  assign ra_data = mem[ra_addr];
  assign rb_data = mem[rb_addr];

endmodule

// File: rtl/cpu_datapath.sv
// CPU datapath: PC, IR, register file, ALU and memory-port steering driven
// purely by control lines. Define DP_FLAGS_EN to add the {N,Z,C} Flags output.
module cpu_datapath
  import DatapathDefs::*;
#(
  parameter int PC_W     = 7,
  parameter int DATA_W   = 16,
  parameter int RF_DEPTH = 16
) (
  input  logic                 Clk,
  input  logic                 ResetN,
  input  logic                 PC_clr,
  input  logic                 PC_up,
  input  logic                 IR_ld,
  input  logic                 D_wr,
  input  logic [DM_ADDR_W-1:0] D_addr,
  input  logic                 RF_s,
  input  logic                 RF_W_en,
  input  logic [RF_ADDR_W-1:0] RF_W_addr,
  input  logic [RF_ADDR_W-1:0] RF_Ra_addr,
  input  logic [RF_ADDR_W-1:0] RF_Rb_addr,
  input  logic [2:0]           Alu_s0,
  output logic [PC_W-1:0]      I_addr,
  input  logic [15:0]          I_data,
  output logic [15:0]          IR,
  output logic [DM_ADDR_W-1:0] DM_addr,
  output logic                 DM_we,
  output logic [DATA_W-1:0]    DM_wdata,
  input  logic [DATA_W-1:0]    DM_rdata,
  output logic [DATA_W-1:0]    ALU_Q
`ifdef DP_FLAGS_EN
  ,
  output logic [2:0]           Flags
`endif
);

  logic [PC_W-1:0]   pc_q;
  logic [15:0]       ir_q;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] alu_q;
  alu_op             op;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      pc_q <= '0;
      ir_q <= '0;
    end else begin
      if (PC_clr)     pc_q <= '0;
      else if (PC_up) pc_q <= pc_q + PC_W'(1);
      if (IR_ld)      ir_q <= I_data;
    end
  end

  // Load data arrives straight from the RAM's registered output; no local buffering.
  assign rf_wdata = RF_s ? DM_rdata : alu_q;

  dp_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (RF_DEPTH)
  ) u_regfile (
    .Clk     (Clk),
    .ResetN  (ResetN),
    .w_en    (RF_W_en),
    .w_addr  (RF_W_addr),
    .w_data  (rf_wdata),
    .ra_addr (RF_Ra_addr),
    .rb_addr (RF_Rb_addr),
    .ra_data (rf_a),
    .rb_data (rf_b)
  );

  assign op = alu_op'(Alu_s0);

  always_comb begin
    alu_q = rf_a;
    case (op)
      ALU_PASS: alu_q = rf_a;
      ALU_ADD:  alu_q = rf_a + rf_b;
      ALU_SUB:  alu_q = rf_a - rf_b;
      ALU_AND:  alu_q = rf_a & rf_b;
      ALU_OR:   alu_q = rf_a | rf_b;
      ALU_XOR:  alu_q = rf_a ^ rf_b;
      ALU_NOT:  alu_q = ~rf_a;
      ALU_INC:  alu_q = rf_a + DATA_W'(1);
      default:  alu_q = rf_a;
    endcase
  end

`ifdef DP_FLAGS_EN
  logic       alu_c;
  logic [2:0] flags_q;

  // Carry/borrow derived from operands and the truncated result.
  always_comb begin
    alu_c = 1'b0;
    case (op)
      ALU_ADD: alu_c = (alu_q < rf_a);
      ALU_SUB: alu_c = (rf_a < rf_b);
      ALU_INC: alu_c = (rf_a == {DATA_W{1'b1}});
      default: alu_c = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      flags_q <= '0;
    end else if (RF_W_en && !RF_s) begin
      flags_q[FLAG_N] <= alu_q[DATA_W-1];
      flags_q[FLAG_Z] <= (alu_q == '0);
      flags_q[FLAG_C] <= alu_c;
    end
  end

  assign Flags = flags_q;
`endif

  assign I_addr   = pc_q;
  assign IR       = ir_q;
  assign DM_addr  = D_addr;
  assign DM_we    = D_wr;
  assign DM_wdata = rf_a;
  assign ALU_Q    = alu_q;

endmodule
